// File: rtl/decode_stage.sv
// ID stage: register-file select, MEM-stage operand bypass, load-use hazard
// detection and the ID/EX pipeline register.
module decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        en,
    input  logic        flush,
    input  logic        ifid_valid,
    input  logic [31:0] ifid_instr,
    input  logic [31:0] ifid_pc,
    output logic [4:0]  rf_rsel1,
    output logic [4:0]  rf_rsel2,
    input  logic [31:0] rf_rdat1,
    input  logic [31:0] rf_rdat2,
    input  logic        exmem_wen,
    input  logic [4:0]  exmem_wsel,
    input  logic [31:0] exmem_wdat,
    output logic        stall,
    output logic        idex_valid,
    output logic [31:0] idex_pc,
    output logic [5:0]  idex_opcode,
    output logic [5:0]  idex_funct,
    output logic [4:0]  idex_shamt,
    output logic [4:0]  idex_rs,
    output logic [4:0]  idex_rt,
    output logic [31:0] idex_rdat1,
    output logic [31:0] idex_rdat2,
    output logic [31:0] idex_imm,
    output logic        idex_wen,
    output logic [4:0]  idex_wsel,
    output logic        idex_memread
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LL    = 6'h30;
    localparam logic [5:0] OP_SC    = 6'h38;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] rdat1;
        logic [31:0] rdat2;
        logic [31:0] imm;
        logic        wen;
        logic [4:0]  wsel;
        logic        memread;
    } idex_t;

    idex_t idex_q, idex_d, dec;

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode   = ifid_instr[31:26];
    assign funct    = ifid_instr[5:0];
    assign rf_rsel1 = ifid_instr[25:21];
    assign rf_rsel2 = ifid_instr[20:16];

    // Load-use: the load in ID/EX has no data until it reaches MEM.
    assign stall = ifid_valid && idex_q.valid && idex_q.memread && (idex_q.wsel != 5'd0)
                   && ((idex_q.wsel == rf_rsel1) || (idex_q.wsel == rf_rsel2));

    always_comb begin
        dec         = '0;
        dec.valid   = ifid_valid;
        dec.pc      = ifid_pc;
        dec.opcode  = opcode;
        dec.funct   = funct;
        dec.shamt   = ifid_instr[10:6];
        dec.rs      = rf_rsel1;
        dec.rt      = rf_rsel2;
        dec.memread = (opcode == OP_LW) || (opcode == OP_LL);

        dec.rdat1 = (exmem_wen && exmem_wsel == rf_rsel1 && rf_rsel1 != 5'd0) ? exmem_wdat : rf_rdat1;
        dec.rdat2 = (exmem_wen && exmem_wsel == rf_rsel2 && rf_rsel2 != 5'd0) ? exmem_wdat : rf_rdat2;

        if (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI)
            dec.imm = {16'h0000, ifid_instr[15:0]};
        else
            dec.imm = {{16{ifid_instr[15]}}, ifid_instr[15:0]};

        case (opcode)
            OP_RTYPE: begin
                dec.wsel = ifid_instr[15:11];
                dec.wen  = (funct != FN_JR);
            end
            OP_JAL: begin
                dec.wsel = 5'd31;
                dec.wen  = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI,
            OP_LUI, OP_LW, OP_LL, OP_SC: begin
                dec.wsel = rf_rsel2;
                dec.wen  = 1'b1;
            end
            default: begin
                dec.wsel = 5'd0;
                dec.wen  = 1'b0;
            end
        endcase
        if (dec.wsel == 5'd0)
            dec.wen = 1'b0;
    end

    // Flush and stall both insert an all-zero bubble; en low freezes everything.
    always_comb begin
        idex_d = idex_q;
        if (en) begin
            if (flush || stall || !ifid_valid)
                idex_d = '0;
            else
                idex_d = dec;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            idex_q    <= '0;
            idex_q.pc <= RESET_PC;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign idex_valid   = idex_q.valid;
    assign idex_pc      = idex_q.pc;
    assign idex_opcode  = idex_q.opcode;
    assign idex_funct   = idex_q.funct;
    assign idex_shamt   = idex_q.shamt;
    assign idex_rs      = idex_q.rs;
    assign idex_rt      = idex_q.rt;
    assign idex_rdat1   = idex_q.rdat1;
    assign idex_rdat2   = idex_q.rdat2;
    assign idex_imm     = idex_q.imm;
    assign idex_wen     = idex_q.wen;
    assign idex_wsel    = idex_q.wsel;
    assign idex_memread = idex_q.memread;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: bypass, $0 guard, load-use, flush/enable
// priority, immediate/destination decode and asynchronous reset.
module tb_decode_stage;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        en, flush, ifid_valid;
    logic [31:0] ifid_instr, ifid_pc;
    logic [4:0]  rf_rsel1, rf_rsel2;
    logic [31:0] rf_rdat1, rf_rdat2;
    logic        exmem_wen;
    logic [4:0]  exmem_wsel;
    logic [31:0] exmem_wdat;
    logic        stall, idex_valid;
    logic [31:0] idex_pc;
    logic [5:0]  idex_opcode, idex_funct;
    logic [4:0]  idex_shamt, idex_rs, idex_rt;
    logic [31:0] idex_rdat1, idex_rdat2, idex_imm;
    logic        idex_wen;
    logic [4:0]  idex_wsel;
    logic        idex_memread;

    int n_tests = 0;
    int n_fail  = 0;

    decode_stage #(.RESET_PC(RST_PC)) dut (
        .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
        .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
        .rf_rsel1(rf_rsel1), .rf_rsel2(rf_rsel2),
        .rf_rdat1(rf_rdat1), .rf_rdat2(rf_rdat2),
        .exmem_wen(exmem_wen), .exmem_wsel(exmem_wsel), .exmem_wdat(exmem_wdat),
        .stall(stall), .idex_valid(idex_valid), .idex_pc(idex_pc),
        .idex_opcode(idex_opcode), .idex_funct(idex_funct), .idex_shamt(idex_shamt),
        .idex_rs(idex_rs), .idex_rt(idex_rt),
        .idex_rdat1(idex_rdat1), .idex_rdat2(idex_rdat2), .idex_imm(idex_imm),
        .idex_wen(idex_wen), .idex_wsel(idex_wsel), .idex_memread(idex_memread)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        ifid_valid = 1'b1;
        ifid_instr = instr;
        ifid_pc    = pc;
    endtask

    initial begin
        nRST = 1'b0; en = 1'b1; flush = 1'b0; ifid_valid = 1'b0;
        ifid_instr = '0; ifid_pc = '0; rf_rdat1 = '0; rf_rdat2 = '0;
        exmem_wen = 1'b0; exmem_wsel = '0; exmem_wdat = '0;
        #12;
        check("rst_pc", idex_pc, RST_PC);
        check("rst_valid", {31'd0, idex_valid}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        nRST = 1'b1;
        step();

        // MEM bypass on both operands
        exmem_wen = 1'b1; exmem_wsel = 5'd8; exmem_wdat = 32'hDEAD_BEEF;
        drive(rtype(5'd8, 5'd8, 5'd9, 6'h20), 32'h0000_0100);
        #1;
        check("rsel1", {27'd0, rf_rsel1}, 32'd8);
        check("rsel2", {27'd0, rf_rsel2}, 32'd8);
        step();
        check("byp_rdat1", idex_rdat1, 32'hDEAD_BEEF);
        check("byp_rdat2", idex_rdat2, 32'hDEAD_BEEF);
        check("byp_wsel", {27'd0, idex_wsel}, 32'd9);
        check("byp_wen", {31'd0, idex_wen}, 32'd1);
        check("byp_valid", {31'd0, idex_valid}, 32'd1);
        check("byp_pc", idex_pc, 32'h0000_0100);
        check("byp_funct", {26'd0, idex_funct}, 32'h20);
        check("byp_rs", {27'd0, idex_rs}, 32'd8);

        // $0 is never bypassed; non-matching operand comes from the RF
        exmem_wsel = 5'd0; exmem_wdat = 32'd5; rf_rdat1 = 32'd0; rf_rdat2 = 32'h1234;
        drive(rtype(5'd0, 5'd3, 5'd10, 6'h20), 32'h0000_0104);
        step();
        check("zero_rdat1", idex_rdat1, 32'd0);
        check("nobyp_rdat2", idex_rdat2, 32'h1234);

        // load-use: LW $4,0($2) then ADD $5,$4,$1
        exmem_wen = 1'b0; rf_rdat2 = 32'd0;
        drive(itype(6'h23, 5'd2, 5'd4, 16'h0000), 32'h0000_0108);
        step();
        check("lw_memread", {31'd0, idex_memread}, 32'd1);
        check("lw_wsel", {27'd0, idex_wsel}, 32'd4);
        drive(rtype(5'd4, 5'd1, 5'd5, 6'h20), 32'h0000_010C);
        #1;
        check("lu_stall", {31'd0, stall}, 32'd1);
        step();
        check("lu_bubble_valid", {31'd0, idex_valid}, 32'd0);
        check("lu_bubble_wen", {31'd0, idex_wen}, 32'd0);
        check("lu_bubble_memread", {31'd0, idex_memread}, 32'd0);
        check("lu_stall_clear", {31'd0, stall}, 32'd0);
        exmem_wen = 1'b1; exmem_wsel = 5'd4; exmem_wdat = 32'd7; rf_rdat1 = 32'd0; rf_rdat2 = 32'd3;
        step();
        check("lu_rdat1", idex_rdat1, 32'd7);
        check("lu_rdat2", idex_rdat2, 32'd3);
        check("lu_wsel", {27'd0, idex_wsel}, 32'd5);
        check("lu_valid", {31'd0, idex_valid}, 32'd1);

        // hazard through rt, and no stall when IF/ID is empty
        exmem_wen = 1'b0;
        drive(itype(6'h30, 5'd2, 5'd6, 16'h0004), 32'h0000_0110);
        step();
        check("ll_memread", {31'd0, idex_memread}, 32'd1);
        drive(rtype(5'd1, 5'd6, 5'd7, 6'h20), 32'h0000_0114);
        #1;
        check("rt_stall", {31'd0, stall}, 32'd1);
        ifid_valid = 1'b0;
        #1;
        check("novalid_stall", {31'd0, stall}, 32'd0);
        step();
        check("novalid_bubble", {31'd0, idex_valid}, 32'd0);

        // flush wins over stall
        drive(itype(6'h23, 5'd2, 5'd4, 16'h0000), 32'h0000_0118);
        step();
        drive(rtype(5'd4, 5'd1, 5'd5, 6'h20), 32'h0000_011C);
        flush = 1'b1;
        #1;
        check("fl_stall", {31'd0, stall}, 32'd1);
        step();
        flush = 1'b0;
        check("fl_valid", {31'd0, idex_valid}, 32'd0);
        check("fl_memread", {31'd0, idex_memread}, 32'd0);

        // ORI zero-extends; then en=0 freezes ID/EX for 3 cycles
        drive(itype(6'h0D, 5'd0, 5'd3, 16'h8000), 32'h0000_0120);
        step();
        check("ori_imm", idex_imm, 32'h0000_8000);
        check("ori_wsel", {27'd0, idex_wsel}, 32'd3);
        en = 1'b0;
        drive(itype(6'h08, 5'd0, 5'd7, 16'h8000), 32'h0000_0124);
        for (int i = 0; i < 3; i++) step();
        check("hold_imm", idex_imm, 32'h0000_8000);
        check("hold_pc", idex_pc, 32'h0000_0120);
        check("hold_wsel", {27'd0, idex_wsel}, 32'd3);
        en = 1'b1;
        step();
        check("addi_imm", idex_imm, 32'hFFFF_8000);
        check("addi_wsel", {27'd0, idex_wsel}, 32'd7);

        drive({6'h03, 26'h0000040}, 32'h0000_0128);
        step();
        check("jal_wsel", {27'd0, idex_wsel}, 32'd31);
        check("jal_wen", {31'd0, idex_wen}, 32'd1);
        drive(itype(6'h2B, 5'd2, 5'd4, 16'h0008), 32'h0000_012C);
        step();
        check("sw_wen", {31'd0, idex_wen}, 32'd0);
        check("sw_wsel", {27'd0, idex_wsel}, 32'd0);
        check("sw_valid", {31'd0, idex_valid}, 32'd1);
        drive(rtype(5'd31, 5'd0, 5'd0, 6'h08), 32'h0000_0130);
        step();
        check("jr_wen", {31'd0, idex_wen}, 32'd0);
        drive(rtype(5'd1, 5'd2, 5'd0, 6'h20), 32'h0000_0134);
        step();
        check("rd0_wen", {31'd0, idex_wen}, 32'd0);

        // asynchronous reset in the middle of a stall
        drive(itype(6'h23, 5'd2, 5'd4, 16'h0000), 32'h0000_0138);
        step();
        drive(rtype(5'd4, 5'd1, 5'd5, 6'h20), 32'h0000_013C);
        #1;
        check("pre_rst_stall", {31'd0, stall}, 32'd1);
        #1;
        nRST = 1'b0;
        #1;
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        check("mid_rst_valid", {31'd0, idex_valid}, 32'd0);
        check("mid_rst_pc", idex_pc, RST_PC);
        check("mid_rst_wsel", {27'd0, idex_wsel}, 32'd0);
        check("mid_rst_memread", {31'd0, idex_memread}, 32'd0);
        nRST = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
